// File: rtl/integrator_gain_sched.sv
// integrator_gain_sched
// Gain scheduler and sequencer for the gyro closed-loop integrator.
// Zeroes the integrator on start or saturation, then walks the gain index
// from P_GAIN_HI down to P_GAIN_LO as the loop error settles, declaring lock
// at P_GAIN_LO. A large error while locked falls back to coarse gain.
// With i_auto_en low, the software gain i_manual_gain is passed through.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_auto_en                    1 = automatic scheduling, 0 = manual
//   i_manual_gain[5:0]           gain index used in manual mode
//   i_sample, i_err[31:0]        error strobe and signed loop error
//   i_lock_th, i_unlock_th       unsigned |err| settle / break thresholds
//   i_dwell[15:0]                settled samples per gain step (0 acts as 1)
//   i_sat_flag_p, i_sat_flag_n   integrator saturation flags
//   o_gain_sel[5:0], o_en, o_zero, o_locked   integrator controls
//   o_state[1:0]                 0 IDLE, 1 ZERO, 2 ACQ, 3 TRACK
//   o_sat_cnt[7:0]               saturation event count, sticks at 255
module integrator_gain_sched #(
    parameter logic [5:0] P_GAIN_HI  = 6'd8,
    parameter logic [5:0] P_GAIN_LO  = 6'd2,
    parameter int         P_ZERO_CYC = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_auto_en,
    input  logic [5:0]  i_manual_gain,
    input  logic        i_sample,
    input  logic [31:0] i_err,
    input  logic [31:0] i_lock_th,
    input  logic [31:0] i_unlock_th,
    input  logic [15:0] i_dwell,
    input  logic        i_sat_flag_p,
    input  logic        i_sat_flag_n,
    output logic [5:0]  o_gain_sel,
    output logic        o_en,
    output logic        o_zero,
    output logic        o_locked,
    output logic [1:0]  o_state,
    output logic [7:0]  o_sat_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ZERO  = 2'd1,
        ACQ   = 2'd2,
        TRACK = 2'd3
    } state_t;

    localparam int TW = (P_ZERO_CYC > 1) ? $clog2(P_ZERO_CYC) : 1;
    // Timer counts down to 0; loading N-1 gives exactly N cycles in ZERO.
    localparam logic [TW-1:0] ZERO_LOAD = TW'(P_ZERO_CYC - 1);

    // Two's-complement magnitude; the most negative value clamps to max positive.
    function automatic logic [31:0] abs_err(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'h8000_0000) begin
            r = 32'h7FFF_FFFF;
        end else if (v[31]) begin
            r = (~v) + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t       state_r, state_s;
    logic [5:0]   gain_r, gain_s;
    logic         en_r, en_s;
    logic         zero_r, zero_s;
    logic         locked_r, locked_s;
    logic [7:0]   sat_cnt_r, sat_cnt_s;
    logic [15:0]  dwell_r, dwell_s;
    logic [TW-1:0] tmr_r, tmr_s;

    logic [31:0]  mag_s;
    logic         settled_s, brk_s, sat_s;
    logic [16:0]  dwell_inc_s, dwell_eff_s;

    // Sample qualification and dwell arithmetic (17 bits so +1 never wraps).
    always_comb begin
        mag_s       = abs_err(i_err);
        settled_s   = i_sample && (mag_s < i_lock_th);
        brk_s       = i_sample && (mag_s > i_unlock_th);
        sat_s       = i_sat_flag_p || i_sat_flag_n;
        dwell_inc_s = {1'b0, dwell_r} + 17'd1;
        dwell_eff_s = (i_dwell == 16'd0) ? 17'd1 : {1'b0, i_dwell};
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_s   = state_r;
        gain_s    = gain_r;
        locked_s  = locked_r;
        sat_cnt_s = sat_cnt_r;
        dwell_s   = dwell_r;
        tmr_s     = tmr_r;
        if (!i_auto_en) begin
            state_s  = IDLE;
            gain_s   = i_manual_gain;
            locked_s = 1'b0;
            dwell_s  = 16'd0;
            tmr_s    = '0;
        end else if (sat_s && (state_r != IDLE)) begin
            state_s  = ZERO;
            gain_s   = P_GAIN_HI;
            locked_s = 1'b0;
            dwell_s  = 16'd0;
            tmr_s    = ZERO_LOAD;
            if (sat_cnt_r != 8'hFF) begin
                sat_cnt_s = sat_cnt_r + 8'd1;
            end else begin
                sat_cnt_s = sat_cnt_r;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = ZERO;
                    gain_s  = P_GAIN_HI;
                    dwell_s = 16'd0;
                    tmr_s   = ZERO_LOAD;
                end
                ZERO: begin
                    if (tmr_r == '0) begin
                        state_s = ACQ;
                    end else begin
                        tmr_s = tmr_r - TW'(1);
                    end
                end
                ACQ: begin
                    if (settled_s) begin
                        if (dwell_inc_s >= dwell_eff_s) begin
                            dwell_s = 16'd0;
                            if (gain_r > P_GAIN_LO) begin
                                gain_s = gain_r - 6'd1;
                            end else begin
                                state_s  = TRACK;
                                locked_s = 1'b1;
                            end
                        end else begin
                            dwell_s = dwell_inc_s[15:0];
                        end
                    end else if (i_sample) begin
                        dwell_s = 16'd0;
                    end else begin
                        dwell_s = dwell_r;
                    end
                end
                TRACK: begin
                    if (brk_s) begin
                        state_s  = ACQ;
                        gain_s   = P_GAIN_HI;
                        locked_s = 1'b0;
                        dwell_s  = 16'd0;
                    end else begin
                        state_s = TRACK;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    gain_s   = P_GAIN_HI;
                    locked_s = 1'b0;
                    dwell_s  = 16'd0;
                    tmr_s    = '0;
                end
            endcase
        end
        en_s   = (state_s != ZERO);
        zero_s = (state_s == ZERO);
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= IDLE;
            gain_r    <= P_GAIN_HI;
            en_r      <= 1'b0;
            zero_r    <= 1'b0;
            locked_r  <= 1'b0;
            sat_cnt_r <= 8'd0;
            dwell_r   <= 16'd0;
            tmr_r     <= '0;
        end else begin
            state_r   <= state_s;
            gain_r    <= gain_s;
            en_r      <= en_s;
            zero_r    <= zero_s;
            locked_r  <= locked_s;
            sat_cnt_r <= sat_cnt_s;
            dwell_r   <= dwell_s;
            tmr_r     <= tmr_s;
        end
    end

    assign o_gain_sel = gain_r;
    assign o_en       = en_r;
    assign o_zero     = zero_r;
    assign o_locked   = locked_r;
    assign o_state    = state_r;
    assign o_sat_cnt  = sat_cnt_r;

endmodule

// File: tb/tb_integrator_gain_sched.sv
// Self-checking bench for integrator_gain_sched: directed vectors, a
// behavioural model compared on every falling edge, and literal checkpoints.
module tb_integrator_gain_sched;

    logic        i_clk;
    logic        i_rst;
    logic        i_auto_en;
    logic [5:0]  i_manual_gain;
    logic        i_sample;
    logic [31:0] i_err;
    logic [31:0] i_lock_th;
    logic [31:0] i_unlock_th;
    logic [15:0] i_dwell;
    logic        i_sat_flag_p;
    logic        i_sat_flag_n;
    logic [5:0]  o_gain_sel;
    logic        o_en;
    logic        o_zero;
    logic        o_locked;
    logic [1:0]  o_state;
    logic [7:0]  o_sat_cnt;

    integrator_gain_sched dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_auto_en(i_auto_en),
        .i_manual_gain(i_manual_gain), .i_sample(i_sample), .i_err(i_err),
        .i_lock_th(i_lock_th), .i_unlock_th(i_unlock_th), .i_dwell(i_dwell),
        .i_sat_flag_p(i_sat_flag_p), .i_sat_flag_n(i_sat_flag_n),
        .o_gain_sel(o_gain_sel), .o_en(o_en), .o_zero(o_zero),
        .o_locked(o_locked), .o_state(o_state), .o_sat_cnt(o_sat_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 IDLE, 1 ZERO, 2 ACQ, 3 TRACK
    int m_state, m_gain, m_en, m_zero, m_locked, m_sat, m_run, m_zero_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_gain = 8; m_en = 0; m_zero = 0; m_locked = 0;
        m_sat = 0; m_run = 0; m_zero_left = 0;
    endtask

    function automatic longint magnitude(input logic [31:0] v);
        longint e;
        e = longint'($signed(v));
        if (e < 0) e = -e;
        if (e > 64'sh7FFF_FFFF) e = 64'sh7FFF_FFFF;
        return e;
    endfunction

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_edge();
        longint a;
        int d;
        if (i_rst) return;
        a = magnitude(i_err);
        d = (i_dwell == 16'd0) ? 1 : int'(i_dwell);
        if (!i_auto_en) begin
            m_state = 0; m_gain = int'(i_manual_gain); m_locked = 0; m_run = 0;
        end else if ((i_sat_flag_p || i_sat_flag_n) && m_state != 0) begin
            m_state = 1; m_zero_left = 4; m_run = 0; m_locked = 0; m_gain = 8;
            if (m_sat < 255) m_sat = m_sat + 1;
        end else if (m_state == 0) begin
            m_state = 1; m_zero_left = 4; m_gain = 8; m_run = 0;
        end else if (m_state == 1) begin
            m_zero_left = m_zero_left - 1;
            if (m_zero_left == 0) m_state = 2;
        end else if (m_state == 2) begin
            if (i_sample) begin
                if (a < longint'(i_lock_th)) begin
                    m_run = m_run + 1;
                    if (m_run >= d) begin
                        m_run = 0;
                        if (m_gain > 2) m_gain = m_gain - 1;
                        else begin m_state = 3; m_locked = 1; end
                    end
                end else m_run = 0;
            end
        end else begin
            if (i_sample && a > longint'(i_unlock_th)) begin
                m_state = 2; m_gain = 8; m_locked = 0; m_run = 0;
            end
        end
        m_en = (m_state != 1) ? 1 : 0;
        m_zero = (m_state == 1) ? 1 : 0;
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("m_gain",   32'(o_gain_sel), 32'(m_gain));
            check("m_en",     32'(o_en),       32'(m_en));
            check("m_zero",   32'(o_zero),     32'(m_zero));
            check("m_locked", 32'(o_locked),   32'(m_locked));
            check("m_state",  32'(o_state),    32'(m_state));
            check("m_satcnt", 32'(o_sat_cnt),  32'(m_sat));
        end
    end

    task automatic step();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
    endtask

    initial begin
        int zc;
        int steps;
        logic [31:0] seq [8];
        seq = '{32'd30, 32'd30, 32'd30, 32'd500, 32'd30, 32'd30, 32'd30, 32'd30};

        i_rst = 1'b1; i_auto_en = 1'b0; i_manual_gain = 6'd0; i_sample = 1'b0;
        i_err = 32'd0; i_lock_th = 32'd100; i_unlock_th = 32'd1000;
        i_dwell = 16'd4; i_sat_flag_p = 1'b0; i_sat_flag_n = 1'b0;
        model_reset();
        #1;
        check("rst_gain", 32'(o_gain_sel), 32'd8);
        check("rst_en", 32'(o_en), 32'd0);
        check("rst_state", 32'(o_state), 32'd0);
        chk_en = 1'b1;
        step(); step();
        i_rst = 1'b0;

        // Manual pass-through
        i_manual_gain = 6'd5;
        step();
        check("man_gain", 32'(o_gain_sel), 32'd5);
        check("man_en", 32'(o_en), 32'd1);
        check("man_state", 32'(o_state), 32'd0);

        // Acquisition from coarse to lock
        i_auto_en = 1'b1; i_sample = 1'b1; i_err = -32'sd30;
        zc = 0; steps = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (o_zero) zc++;
            if (k < 33 && o_gain_sel != 6'(m_gain)) steps++;
            if (k == 5) check("acq_en_rise", 32'(o_en), 32'd1);
            if (k == 9) check("acq_first_step", 32'(o_gain_sel), 32'd7);
            if (k == 32) check("acq_prelock", 32'(o_state), 32'd2);
            if (k == 33) begin
                check("acq_lock_state", 32'(o_state), 32'd3);
                check("acq_locked", 32'(o_locked), 32'd1);
                check("acq_gain_lo", 32'(o_gain_sel), 32'd2);
            end
        end
        check("acq_zero_cycles", 32'(zc), 32'd4);
        check("model_locked", 32'(m_locked), 32'd1);

        // Lock loss on the most negative error
        i_err = 32'h8000_0000;
        step();
        check("loss_locked", 32'(o_locked), 32'd0);
        check("loss_gain", 32'(o_gain_sel), 32'd8);
        check("loss_state", 32'(o_state), 32'd2);
        check("loss_zero", 32'(o_zero), 32'd0);

        // Dwell counter cleared by an unsettled sample
        for (int i = 0; i < 8; i++) begin
            i_err = seq[i];
            step();
            check("dwell_seq", 32'(o_gain_sel), (i == 7) ? 32'd7 : 32'd8);
        end
        // |err| equal to the lock threshold is not settled
        i_err = 32'd100;
        step();
        i_err = 32'd30;
        step(); step(); step();
        check("th_equal_nostep", 32'(o_gain_sel), 32'd7);
        step();
        check("th_equal_step", 32'(o_gain_sel), 32'd6);

        // Saturation and re-arm inside ZERO
        i_sample = 1'b0;
        i_sat_flag_n = 1'b1;
        step();
        i_sat_flag_n = 1'b0;
        check("sat_state", 32'(o_state), 32'd1);
        check("sat_zero", 32'(o_zero), 32'd1);
        check("sat_en", 32'(o_en), 32'd0);
        check("sat_cnt1", 32'(o_sat_cnt), 32'd1);
        step(); step();
        i_sat_flag_p = 1'b1;
        step();
        i_sat_flag_p = 1'b0;
        check("sat_cnt2", 32'(o_sat_cnt), 32'd2);
        zc = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (o_zero) zc++;
        end
        check("sat_rearm_len", 32'(zc), 32'd4);

        // Manual request beats saturation
        i_auto_en = 1'b0; i_sat_flag_p = 1'b1;
        step();
        i_sat_flag_p = 1'b0;
        check("prio_state", 32'(o_state), 32'd0);
        check("prio_satcnt", 32'(o_sat_cnt), 32'd2);

        // Dwell of 0 behaves as 1: lock after 5 + 7 edges
        i_auto_en = 1'b1; i_dwell = 16'd0; i_sample = 1'b1; i_err = -32'sd30;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 11) check("dw0_prelock", 32'(o_state), 32'd2);
            if (k == 12) check("dw0_lock", 32'(o_state), 32'd3);
        end

        // Unlock threshold boundary
        i_err = 32'd1000;
        step();
        check("unlock_equal", 32'(o_state), 32'd3);
        i_err = -32'sd1001;
        step();
        check("unlock_break", 32'(o_state), 32'd2);
        i_err = 32'd5;
        for (int k = 0; k < 7; k++) step();
        check("relock", 32'(o_state), 32'd3);

        // Asynchronous reset in TRACK
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        check("arst_gain", 32'(o_gain_sel), 32'd8);
        check("arst_en", 32'(o_en), 32'd0);
        check("arst_zero", 32'(o_zero), 32'd0);
        check("arst_locked", 32'(o_locked), 32'd0);
        check("arst_state", 32'(o_state), 32'd0);
        check("arst_satcnt", 32'(o_sat_cnt), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0; i_auto_en = 1'b0; i_manual_gain = 6'd3;
        step(); step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
